// File: rtl/line_follow_pwm_ctrl_if.sv
// Bundle of run control, sensor, duty and motor-driver signals for the line follower.
// Latency: none, wires only.
// Backpressure: none, every signal is sampled or driven each cycle.
interface line_follow_pwm_ctrl_if #(
    parameter int NSENS = 3,
    parameter int PWM_W = 8
);
    logic              en;
    logic [NSENS-1:0]  sens;
    logic [PWM_W-1:0]  duty_fwd;
    logic [PWM_W-1:0]  duty_turn;
    logic              OUT1;
    logic              OUT2;
    logic              OUT3;
    logic              OUT4;
    logic              ENA;
    logic              ENB;
    logic [2:0]        state;
    logic              lost;

    // Stimulus side: sensor front end and host controls.
    modport master (
        output en, sens, duty_fwd, duty_turn,
        input  OUT1, OUT2, OUT3, OUT4, ENA, ENB, state, lost
    );

    // Controller side.
    modport slave (
        input  en, sens, duty_fwd, duty_turn,
        output OUT1, OUT2, OUT3, OUT4, ENA, ENB, state, lost
    );
endinterface

// File: rtl/line_follow_pwm_ctrl.sv
// Line follower: debounce sensors, classify line position, run FSM, drive dual H-bridge with PWM.
// Latency: raw sensor to state FILT edges; state to motor pins one further edge.
// Backpressure: none; inputs sampled every cycle, all outputs registered.
module line_follow_pwm_ctrl #(
    parameter int NSENS   = 3,
    parameter int PWM_W   = 8,
    parameter int FILT    = 4,
    parameter int LOST_TO = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    line_follow_pwm_ctrl_if.slave bus
);
    localparam int C   = (NSENS - 1) / 2;
    // Filter counter only needs to reach FILT-1 before the flip.
    localparam int FCW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int TW  = $clog2(LOST_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_LEFT   = 3'd2,
        S_RIGHT  = 3'd3,
        S_SEARCH = 3'd4,
        S_STOP   = 3'd5
    } state_e;

    logic [NSENS-1:0]           filt_q, filt_d;
    logic [NSENS-1:0][FCW-1:0]  fcnt_q, fcnt_d;
    state_e                     state_q, state_d;
    logic                       lost_q, lost_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       last_dir_q, last_dir_d;   // 0 = left, 1 = right
    logic [PWM_W-1:0]           pwm_cnt_q;
    logic [3:0]                 out_q, out_d;             // {OUT1, OUT2, OUT3, OUT4}
    logic                       ena_q, ena_d, enb_q, enb_d;

    logic all_s, none_s, lft_s, rgt_s, mid_s;

    assign all_s  = &filt_q;
    assign none_s = ~|filt_q;
    assign lft_s  = |filt_q[NSENS-1:C+1];
    assign rgt_s  = |filt_q[C-1:0];
    assign mid_s  = filt_q[C];

    // Per-bit debounce: flip only after FILT consecutive disagreeing edges.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < NSENS; i++) begin
            if (bus.sens[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCW'(FILT - 1)) begin
                    filt_d[i] = bus.sens[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Run FSM next state, lost flag, search timer and remembered turn direction.
    always_comb begin
        state_d    = state_q;
        lost_d     = lost_q;
        last_dir_d = last_dir_q;
        timer_d    = '0;
        if (state_q == S_SEARCH) begin
            timer_d = timer_q + 1'b1;
        end
        if (!bus.en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FWD;
                S_STOP: state_d = S_STOP;
                default: begin
                    // Timeout beats everything except en=0, so the give-up edge is exact.
                    if (state_q == S_SEARCH && timer_q == TW'(LOST_TO - 1)) begin
                        state_d = S_STOP;
                        lost_d  = 1'b1;
                    end else if (all_s) begin
                        state_d = S_STOP;
                    end else if (lft_s && !rgt_s) begin
                        state_d = S_LEFT;
                    end else if (rgt_s && !lft_s) begin
                        state_d = S_RIGHT;
                    end else if (mid_s || (lft_s && rgt_s)) begin
                        state_d = S_FWD;
                    end else if (none_s) begin
                        state_d = S_SEARCH;
                    end
                end
            endcase
        end
        if (state_d == S_IDLE) begin
            lost_d = 1'b0;
        end
        if (state_d == S_LEFT) begin
            last_dir_d = 1'b0;
        end else if (state_d == S_RIGHT) begin
            last_dir_d = 1'b1;
        end
    end

    // Motor pin decode from the current state; registered so pins lag state by one edge.
    always_comb begin
        out_d = 4'b0000;
        ena_d = 1'b0;
        enb_d = 1'b0;
        case (state_q)
            S_FWD: begin
                out_d = 4'b1010;
                ena_d = pwm_cnt_q < bus.duty_fwd;
                enb_d = pwm_cnt_q < bus.duty_fwd;
            end
            S_LEFT: begin
                out_d = 4'b0010;
                enb_d = pwm_cnt_q < bus.duty_turn;
            end
            S_RIGHT: begin
                out_d = 4'b1000;
                ena_d = pwm_cnt_q < bus.duty_turn;
            end
            S_SEARCH: begin
                // Pivot toward the side the line was last seen on.
                out_d = last_dir_q ? 4'b1001 : 4'b0110;
                ena_d = pwm_cnt_q < bus.duty_turn;
                enb_d = pwm_cnt_q < bus.duty_turn;
            end
            default: ;
        endcase
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= '0;
            fcnt_q     <= '0;
            state_q    <= S_IDLE;
            lost_q     <= 1'b0;
            timer_q    <= '0;
            last_dir_q <= 1'b0;
            pwm_cnt_q  <= '0;
            out_q      <= 4'b0000;
            ena_q      <= 1'b0;
            enb_q      <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            lost_q     <= lost_d;
            timer_q    <= timer_d;
            last_dir_q <= last_dir_d;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            out_q      <= out_d;
            ena_q      <= ena_d;
            enb_q      <= enb_d;
        end
    end

    assign bus.OUT1  = out_q[3];
    assign bus.OUT2  = out_q[2];
    assign bus.OUT3  = out_q[1];
    assign bus.OUT4  = out_q[0];
    assign bus.ENA   = ena_q;
    assign bus.ENB   = enb_q;
    assign bus.state = state_q;
    assign bus.lost  = lost_q;
endmodule

// File: tb/tb_line_follow_pwm_ctrl.sv
// Self-checking bench for line_follow_pwm_ctrl: vector table plus hand sequences.
// Expected values are queued when stimulus is driven and compared when outputs are sampled.
// Outputs sampled 1 time unit after each rising edge.
module tb_line_follow_pwm_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    line_follow_pwm_ctrl_if #(.NSENS(3), .PWM_W(8)) bus ();

    line_follow_pwm_ctrl #(
        .NSENS(3), .PWM_W(8), .FILT(4), .LOST_TO(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    string name_q[$];
    int    exp_q[$];

    typedef struct {
        logic       en;
        logic [2:0] sens;
        int         cycles;
        int         st;
        int         pins;
        int         lost;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int ev);
        name_q.push_back(nm);
        exp_q.push_back(ev);
    endtask

    task automatic check_next(input int act);
        string nm;
        int    ev;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d with nothing expected", act);
        end else begin
            nm = name_q.pop_front();
            ev = exp_q.pop_front();
            if (act != ev) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", nm, act, ev);
            end
        end
    endtask

    function automatic int pins();
        return int'({bus.OUT1, bus.OUT2, bus.OUT3, bus.OUT4});
    endfunction

    task automatic chk(input string nm, input int ev, input int act);
        expect_val(nm, ev);
        check_next(act);
    endtask

    task automatic wait_state(input int st, input int budget, input string nm);
        int n = 0;
        while (int'(bus.state) != st && n < budget) begin
            tick();
            n++;
        end
        chk(nm, st, int'(bus.state));
    endtask

    task automatic count_en(output int ca, output int cb);
        ca = 0;
        cb = 0;
        repeat (256) begin
            tick();
            ca += int'(bus.ENA);
            cb += int'(bus.ENB);
        end
    endtask

    initial begin
        int ca, cb, bad;

        tbl[0] = '{1'b1, 3'b100, 8, 2, 4'b0010, 0};
        tbl[1] = '{1'b1, 3'b001, 8, 3, 4'b1000, 0};
        tbl[2] = '{1'b1, 3'b101, 8, 1, 4'b1010, 0};
        tbl[3] = '{1'b1, 3'b110, 8, 2, 4'b0010, 0};
        tbl[4] = '{1'b1, 3'b011, 8, 3, 4'b1000, 0};
        tbl[5] = '{1'b1, 3'b010, 8, 1, 4'b1010, 0};
        tbl[6] = '{1'b1, 3'b111, 8, 5, 4'b0000, 0};
        tbl[7] = '{1'b1, 3'b010, 8, 5, 4'b0000, 0};
        tbl[8] = '{1'b0, 3'b010, 8, 0, 4'b0000, 0};
        tbl[9] = '{1'b1, 3'b010, 8, 1, 4'b1010, 0};

        // Reset with sensors already on the line.
        rst_n         = 1'b0;
        bus.en        = 1'b1;
        bus.sens      = 3'b010;
        bus.duty_fwd  = 8'd64;
        bus.duty_turn = 8'd128;
        repeat (3) tick();
        chk("rst_state", 0, int'(bus.state));
        chk("rst_pins",  0, pins());
        chk("rst_ena",   0, int'(bus.ENA));
        chk("rst_enb",   0, int'(bus.ENB));
        chk("rst_lost",  0, int'(bus.lost));

        // Release: IDLE->FWD, filtered still 000 so SEARCH, then FWD once 010 is filtered in.
        rst_n = 1'b1;
        tick();
        chk("rel_e1_state", 1, int'(bus.state));
        tick();
        chk("rel_e2_state", 4, int'(bus.state));
        tick();
        tick();
        chk("rel_e4_state", 4, int'(bus.state));
        chk("rel_e4_pins_search_left", 4'b0110, pins());
        tick();
        chk("rel_e5_state", 1, int'(bus.state));
        tick();
        chk("rel_e6_pins", 4'b1010, pins());

        // Steering vector table.
        for (int i = 0; i < 10; i++) begin
            bus.en   = tbl[i].en;
            bus.sens = tbl[i].sens;
            expect_val($sformatf("vec%0d_state", i), tbl[i].st);
            expect_val($sformatf("vec%0d_pins", i), tbl[i].pins);
            expect_val($sformatf("vec%0d_lost", i), tbl[i].lost);
            repeat (tbl[i].cycles) tick();
            check_next(int'(bus.state));
            check_next(pins());
            check_next(int'(bus.lost));
        end

        // PWM duty in FWD.
        expect_val("pwm64_ena", 64);
        expect_val("pwm64_enb", 64);
        count_en(ca, cb);
        check_next(ca);
        check_next(cb);
        bus.duty_fwd = 8'd0;
        repeat (2) tick();
        expect_val("pwm0_ena", 0);
        expect_val("pwm0_enb", 0);
        count_en(ca, cb);
        check_next(ca);
        check_next(cb);
        bus.duty_fwd = 8'd255;
        repeat (2) tick();
        expect_val("pwm255_ena", 255);
        expect_val("pwm255_enb", 255);
        count_en(ca, cb);
        check_next(ca);
        check_next(cb);
        bus.duty_fwd = 8'd64;

        // RIGHT uses duty_turn on ENA only; also leaves last_dir = RIGHT.
        bus.sens = 3'b001;
        repeat (8) tick();
        chk("right_state", 3, int'(bus.state));
        expect_val("right_ena", 128);
        expect_val("right_enb", 0);
        count_en(ca, cb);
        check_next(ca);
        check_next(cb);
        bus.sens = 3'b010;
        repeat (8) tick();
        chk("back_fwd_state", 1, int'(bus.state));

        // Filter: 3-cycle dropout is swallowed.
        bus.sens = 3'b000;
        repeat (3) tick();
        bus.sens = 3'b010;
        bad = 0;
        repeat (8) begin
            tick();
            if (int'(bus.state) != 1) bad++;
        end
        chk("glitch3_cycles_not_fwd", 0, bad);

        // Filter: 4-cycle dropout reaches SEARCH exactly FILT edges later.
        bus.sens = 3'b000;
        repeat (4) tick();
        chk("drop4_k3_state", 1, int'(bus.state));
        bus.sens = 3'b010;
        tick();
        chk("drop4_k4_state", 4, int'(bus.state));
        tick();
        chk("drop4_pins_search_right", 4'b1001, pins());
        repeat (2) tick();
        chk("drop4_k7_state", 4, int'(bus.state));
        tick();
        chk("drop4_k8_state", 1, int'(bus.state));

        // Search timeout after 64 cycles in SEARCH.
        repeat (2) tick();
        bus.sens = 3'b000;
        repeat (5) tick();
        chk("to_enter_state", 4, int'(bus.state));
        bad = 0;
        repeat (63) begin
            tick();
            if (pins() != 4'b1001 || bus.ENA != bus.ENB) bad++;
        end
        chk("to_search_pin_errs", 0, bad);
        chk("to_e63_state", 4, int'(bus.state));
        chk("to_e63_lost", 0, int'(bus.lost));
        tick();
        chk("to_e64_state", 5, int'(bus.state));
        chk("to_e64_lost", 1, int'(bus.lost));
        tick();
        chk("to_stop_pins", 0, pins());
        bus.en = 1'b0;
        tick();
        chk("to_idle_state", 0, int'(bus.state));
        chk("to_idle_lost", 0, int'(bus.lost));

        // Re-acquire at search cycle 30.
        bus.en = 1'b1;
        wait_state(4, 10, "reacq_enter_search");
        repeat (26) tick();
        bus.sens = 3'b010;
        repeat (4) tick();
        chk("reacq_e30_state", 4, int'(bus.state));
        tick();
        chk("reacq_state", 1, int'(bus.state));
        chk("reacq_lost", 0, int'(bus.lost));

        // Asynchronous reset in the middle of SEARCH.
        bus.sens = 3'b000;
        wait_state(4, 20, "arst_enter_search");
        repeat (2) tick();
        chk("arst_pre_pins", 4'b1001, pins());
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 0, int'(bus.state));
        chk("arst_pins",  0, pins());
        chk("arst_ena",   0, int'(bus.ENA));
        chk("arst_enb",   0, int'(bus.ENB));
        chk("arst_lost",  0, int'(bus.lost));
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("arst_after_state", 4, int'(bus.state));
        tick();
        chk("arst_last_dir_left_pins", 4'b0110, pins());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/line_follow_pwm_ctrl.md
# line_follow_pwm_ctrl

Parametrised line-following drive controller. It debounces an N-wide reflective sensor array and classifies the line position. A run-state machine (idle, forward, turn, search, stop) uses that position to drive a dual H-bridge: direction pins OUT1–OUT4 and PWM enables ENA/ENB. It sits between the sensor pins and the motor driver, and replaces hand-driven state selection with an internal FSM plus lost-line timeout.

## Interface
- NSENS, 3, sensor count; odd, ≥3; bit NSENS-1 = leftmost, centre index C=(NSENS-1)/2
- PWM_W, 8, PWM counter/duty width
- FILT, 4, consecutive cycles a raw sensor must disagree with its filtered value before the filtered value flips; ≥1
- LOST_TO, 1000, cycles in SEARCH before giving up; ≥1

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 forces IDLE
- sens  in  NSENS  raw sensors, 1 = line seen
- duty_fwd  in  PWM_W  duty for FWD
- duty_turn  in  PWM_W  duty for LEFT/RIGHT/SEARCH
- OUT1, OUT2  out  1  left-motor direction (10 fwd, 01 rev, 00 coast)
- OUT3, OUT4  out  1  right-motor direction (same encoding)
- ENA, ENB  out  1  left/right PWM enable
- state  out  3  IDLE=0, FWD=1, LEFT=2, RIGHT=3, SEARCH=4, STOP=5
- lost  out  1  set when SEARCH timed out; sticky until IDLE

## Operation
- Filter, per bit: a counter is cleared whenever raw equals filtered. Otherwise it increments, and on the FILT-th consecutive mismatching edge the filtered bit takes the raw value and the counter clears.
- Classify filtered f:
  - none: f == 0
  - all: f all ones
  - lft: |f[NSENS-1:C+1]
  - rgt: |f[C-1:0]
  - mid: f[C]
- Priority, in every state except IDLE/STOP, evaluated every cycle:
  1. en=0 → IDLE (from any state, highest priority)
  2. all → STOP
  3. lft & !rgt → LEFT
  4. rgt & !lft → RIGHT
  5. mid, or lft & rgt → FWD
  6. none → SEARCH
- IDLE: en=1 → FWD on next edge.
- STOP: held until en=0.
- last_dir register: loads LEFT on entering LEFT and RIGHT on entering RIGHT; reset value LEFT.
- Search timer:
  - cleared in every state other than SEARCH, and increments each cycle in SEARCH.
  - On the edge where the timer reaches LOST_TO, the FSM goes to STOP and lost is set.
  - Re-acquiring the line before that exits SEARCH normally, with lost staying 0.
- Drive per state, as left dir / right dir / duty:
  - IDLE, STOP: coast/coast, ENA=ENB=0
  - FWD: fwd/fwd, duty_fwd both
  - LEFT: coast/fwd, ENA=0, ENB duty_turn
  - RIGHT: fwd/coast, ENA duty_turn, ENB=0
  - SEARCH: pivot toward last_dir. LEFT gives rev/fwd; RIGHT gives fwd/rev. Both use duty_turn.
- PWM:
  - free-running PWM_W-bit counter pwm_cnt, wraps 2^PWM_W-1 → 0
  - ENx = (pwm_cnt < duty)
  - duty 0 → constant 0; duty 2^PWM_W-1 → high 2^PWM_W-1 of every 2^PWM_W cycles
- Duty inputs are sampled every cycle; no holding to period boundary.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, lost=0, OUT1–4=0, ENA=ENB=0
  - filtered=0, filter counters=0, pwm_cnt=0, search timer=0, last_dir=LEFT
- Release is acted on at the first rising edge with rst_n=1.
- Sensor→state: a raw change stable from edge k appears in filtered at edge k+FILT-1 and in state at edge k+FILT.
- State→pins: OUT1–4/ENA/ENB are registered from state, last_dir and pwm_cnt, so they lag state by one edge. Sensor→motor latency is therefore FILT+1 edges.
- Raw glitches shorter than FILT cycles never reach state.
- Simultaneous en=0 and any sensor event: IDLE wins.
- en=0 in STOP with lost=1: IDLE and lost=0 on the same edge.
- Reset mid-SEARCH discards the timer and last_dir.

## Test plan
- Reset/idle: hold rst_n=0 with sens=010 and en=1. Expect all outputs 0 and state=0. Release: state=1 at 4 edges after sens settles (FILT=4). OUT1..4=1010 one edge later.
- PWM: state FWD, duty_fwd=64, PWM_W=8. ENA=ENB high for exactly 64 of each 256 cycles. duty=0 keeps ENA=0; duty=255 gives 255/256.
- Steering: sens 010→100 → state=2, ENA=0, ENB at duty_turn. Then 001 → state=3. Then 101 → state=1. Then 111 → state=5, and it stays 5 with sens=010 until en=0.
- Filter: 3-cycle pulse 010→000→010 with FILT=4 → state stays 1. A 4-cycle pulse → state=4 at the expected edge.
- Search timeout: LOST_TO=64, last_dir=RIGHT, sens=000. Pins are OUT1..4=1001 with both ENs at duty_turn. state=5 and lost=1 after 64 cycles in SEARCH. en=0 → state=0, lost=0.
- Re-acquire and async reset: sens=010 at search cycle 30 → FWD, lost=0. Assert rst_n mid-SEARCH: outputs go 0 immediately, not at the next edge.
